// File: rtl/led_effects_if.sv
// led_effects_if: Avalon-MM register slave bundle for the LED effects stage.
interface led_effects_if;
    logic [1:0] address;
    logic       read;
    logic [7:0] readdata;
    logic       write;
    logic [7:0] writedata;
    modport master (output address, read, write, writedata, input readdata);
    modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/led_effects.sv
// led_effects: drives LEDs from the pattern register with PWM dimming and
// blink/chase/alternate effects, configured over its own Avalon-MM slave.
module led_effects #(
    parameter int PRESCALE = 50000
) (
    input  logic            csi_clk,
    input  logic            csi_reset,
    led_effects_if.slave    avs,
    input  logic [7:0]      pattern_in,
    output logic [7:0]      led_out
);
    localparam int PW = $clog2(PRESCALE);
    logic          r_enable, r_phase, r_reload;
    logic [1:0]    r_mode;
    logic [7:0]    r_bright, r_rate, r_readdata, r_led, r_rate_cnt, r_pwm, r_rot, r_pat_prev;
    logic [PW-1:0] r_presc;
    logic          w_ctrl_wr, w_tick, w_step, w_pwm_on, w_reload;
    logic [7:0]    w_eff, w_rd;
    assign w_ctrl_wr = avs.write && avs.address == 2'd0;
    assign w_tick    = r_enable && r_presc == PW'(PRESCALE - 1);
    assign w_step    = w_tick && r_rate_cnt == r_rate;
    assign w_pwm_on  = r_pwm < r_bright || r_bright == 8'hFF;
    // A pending CTRL-write reload or a fresh pattern outranks a chase step.
    assign w_reload  = r_reload || pattern_in != r_pat_prev;
    assign led_out      = r_led;
    assign avs.readdata = r_readdata;
    always_comb begin
        w_eff = r_mode == 2'd2 ? r_rot :
                r_mode == 2'd0 ? pattern_in :
                r_phase        ? (r_mode[1] ? ~pattern_in : 8'h00) : pattern_in;
        w_rd  = avs.address == 2'd0 ? {r_enable, 5'b0, r_mode} :
                avs.address == 2'd1 ? r_bright :
                avs.address == 2'd2 ? r_rate : r_led;
    end
    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            r_enable   <= 1'b1;
            r_mode     <= 2'd0;
            r_bright   <= 8'hFF;
            r_rate     <= 8'd99;
            r_readdata <= 8'h00;
            r_led      <= 8'h00;
            r_presc    <= '0;
            r_rate_cnt <= 8'h00;
            r_pwm      <= 8'h00;
            r_phase    <= 1'b0;
            r_reload   <= 1'b0;
            r_rot      <= 8'h00;
            r_pat_prev <= 8'h00;
        end else begin
            if (w_ctrl_wr)
                {r_enable, r_mode} <= {avs.writedata[7], avs.writedata[1:0]};
            if (avs.write && avs.address == 2'd1)
                r_bright <= avs.writedata;
            if (avs.write && avs.address == 2'd2)
                r_rate <= avs.writedata;
            if (avs.read)
                r_readdata <= w_rd;
            r_presc <= (!r_enable || w_ctrl_wr || w_tick) ? '0 : r_presc + 1'b1;
            // A count left above a newly lowered RATE clears without stepping.
            if (!r_enable || w_ctrl_wr)
                r_rate_cnt <= 8'h00;
            else if (w_tick)
                r_rate_cnt <= r_rate_cnt >= r_rate ? 8'h00 : r_rate_cnt + 8'h01;
            r_pwm      <= r_enable ? r_pwm + 8'h01 : 8'h00;
            r_phase    <= w_ctrl_wr ? 1'b0 : r_phase ^ w_step;
            r_reload   <= w_ctrl_wr;
            r_pat_prev <= pattern_in;
            r_rot      <= w_reload ? pattern_in : w_step ? {r_rot[6:0], r_rot[7]} : r_rot;
            r_led      <= r_enable ? (w_eff & {8{w_pwm_on}}) : 8'h00;
        end
    end
endmodule
